// File: rtl/demux_1x4_stream.sv
// rtl/demux_1x4_stream.sv - 1-to-4 stream demux, one-entry holding register per channel
// Optional per-channel accepted-word counters enabled by DEMUX_CNT_EN.
module demux_1x4_stream #(
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic [1:0]    in_sel,
    output logic [3:0]    out_valid,
    input  logic [3:0]    out_ready,
    output logic [DW-1:0] out_a,
    output logic [DW-1:0] out_b,
    output logic [DW-1:0] out_c,
    output logic [DW-1:0] out_d
`ifdef DEMUX_CNT_EN
    ,
    output logic [7:0]    xfer_cnt_a,
    output logic [7:0]    xfer_cnt_b,
    output logic [7:0]    xfer_cnt_c,
    output logic [7:0]    xfer_cnt_d
`endif
);

    logic [3:0]    r_valid;
    logic [DW-1:0] r_data [4];
    logic          w_in_ready;
    logic [3:0]    w_load;

    // A full channel can still accept when its word leaves on the same edge.
    always_comb begin
        w_in_ready = ~r_valid[in_sel] | out_ready[in_sel];
        w_load     = 4'b0000;
        if (in_valid && w_in_ready) begin
            w_load = 4'b0001 << in_sel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 4'b0000;
            for (int k = 0; k < 4; k++) begin
                r_data[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (w_load[k]) begin
                    r_data[k]  <= in_data;
                    r_valid[k] <= 1'b1;
                end else if (out_ready[k]) begin
                    r_valid[k] <= 1'b0;
                end
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_valid;
    assign out_a     = r_data[0];
    assign out_b     = r_data[1];
    assign out_c     = r_data[2];
    assign out_d     = r_data[3];

`ifdef DEMUX_CNT_EN
    logic [7:0] r_cnt [4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                r_cnt[k] <= 8'd0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (w_load[k]) begin
                    r_cnt[k] <= r_cnt[k] + 8'd1;
                end
            end
        end
    end

    assign xfer_cnt_a = r_cnt[0];
    assign xfer_cnt_b = r_cnt[1];
    assign xfer_cnt_c = r_cnt[2];
    assign xfer_cnt_d = r_cnt[3];
`endif

endmodule

// File: tb/tb_demux_1x4_stream.sv
// tb/tb_demux_1x4_stream.sv - scoreboard bench for demux_1x4_stream
module tb_demux_1x4_stream;

    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [1:0]    in_sel;
    logic [3:0]    out_valid;
    logic [3:0]    out_ready;
    logic [DW-1:0] out_a, out_b, out_c, out_d;
`ifdef DEMUX_CNT_EN
    logic [7:0]    xfer_cnt_a, xfer_cnt_b, xfer_cnt_c, xfer_cnt_d;
`endif

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] q [4][$];
    logic [7:0]    mcnt [4];

    demux_1x4_stream #(.DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_c     (out_c),
        .out_d     (out_d)
`ifdef DEMUX_CNT_EN
        ,
        .xfer_cnt_a(xfer_cnt_a),
        .xfer_cnt_b(xfer_cnt_b),
        .xfer_cnt_c(xfer_cnt_c),
        .xfer_cnt_d(xfer_cnt_d)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int out_of(input int k);
        case (k)
            0:       return int'(out_a);
            1:       return int'(out_b);
            2:       return int'(out_c);
            default: return int'(out_d);
        endcase
    endfunction

`ifdef DEMUX_CNT_EN
    function automatic int cnt_of(input int k);
        case (k)
            0:       return int'(xfer_cnt_a);
            1:       return int'(xfer_cnt_b);
            2:       return int'(xfer_cnt_c);
            default: return int'(xfer_cnt_d);
        endcase
    endfunction
`endif

    task automatic drive(input logic v, input logic [1:0] s, input logic [DW-1:0] d,
                         input logic [3:0] r);
        in_valid  = v;
        in_sel    = s;
        in_data   = d;
        out_ready = r;
    endtask

    task automatic clear_model();
        for (int k = 0; k < 4; k++) begin
            q[k].delete();
            mcnt[k] = 8'd0;
        end
    endtask

    // Stimulus side: a word is accepted when its channel holds nothing after this edge's drains.
    always @(posedge clk) begin
        if (rst_n && in_valid && q[in_sel].size() == 0) begin
            q[in_sel].push_back(in_data);
            mcnt[in_sel] = mcnt[in_sel] + 8'd1;
        end
    end

    // Monitor: compare presented outputs, then retire words the consumer takes on the next edge.
    always @(negedge clk) begin
        if (rst_n) begin
            check("in_ready", int'(in_ready),
                  int'(q[in_sel].size() == 0 || out_ready[in_sel]));
            for (int k = 0; k < 4; k++) begin
                check($sformatf("out_valid[%0d]", k), int'(out_valid[k]), int'(q[k].size() != 0));
                if (q[k].size() != 0) begin
                    check($sformatf("out_data[%0d]", k), out_of(k), int'(q[k][0]));
                end
`ifdef DEMUX_CNT_EN
                check($sformatf("xfer_cnt[%0d]", k), cnt_of(k), int'(mcnt[k]));
`endif
            end
            for (int k = 0; k < 4; k++) begin
                if (q[k].size() != 0 && out_ready[k]) begin
                    void'(q[k].pop_front());
                end
            end
        end
    end

    initial begin
        clear_model();
        rst_n = 1'b0;
        drive(1'b1, 2'd2, 4'hA, 4'b0000);
        repeat (3) @(negedge clk);
        check("reset out_valid", int'(out_valid), 0);
        check("reset in_ready", int'(in_ready), 1);
        check("reset out_c", int'(out_c), 0);
        rst_n = 1'b1;

        @(negedge clk);
        check("sel2 out_valid", int'(out_valid), 4'b0100);
        check("sel2 out_c", int'(out_c), 4'hA);
        check("sel2 stall in_ready", int'(in_ready), 0);

        @(posedge clk); #1 drive(1'b1, 2'd1, 4'h3, 4'b0000);
        @(posedge clk); #1 drive(1'b1, 2'd0, 4'h9, 4'b0000);
        @(posedge clk); #1 drive(1'b1, 2'd3, 4'h5, 4'b0000);
        @(posedge clk); #1 drive(1'b1, 2'd1, 4'h7, 4'b0010);
        @(negedge clk);
        check("other ch out_d", int'(out_d), 4'h5);
        check("other ch out_a held", int'(out_a), 4'h9);
        check("reload in_ready", int'(in_ready), 1);
        check("pre-reload out_b", int'(out_b), 4'h3);
        @(posedge clk); #1 drive(1'b0, 2'd0, 4'h0, 4'b0000);
        @(negedge clk);
        check("reload out_b", int'(out_b), 4'h7);
        check("all full out_valid", int'(out_valid), 4'b1111);

        #2 rst_n = 1'b0;
        #1;
        check("async reset out_valid", int'(out_valid), 0);
        check("async reset out_b", int'(out_b), 0);
        check("async reset in_ready", int'(in_ready), 1);
        clear_model();
        @(posedge clk); #1 rst_n = 1'b1;

`ifdef DEMUX_CNT_EN
        for (int i = 0; i < 256; i++) begin
            @(posedge clk); #1 drive(1'b1, 2'd0, DW'($urandom), 4'b0001);
        end
        @(posedge clk); #1 drive(1'b0, 2'd0, 4'h0, 4'b0001);
        check("cnt_a wrap", int'(xfer_cnt_a), 0);
        check("cnt_b idle", int'(xfer_cnt_b), 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1 drive(1'b1, 2'd0, DW'($urandom), 4'b0001);
        end
        @(posedge clk); #1 drive(1'b0, 2'd0, 4'h0, 4'b0001);
        check("cnt_a after 3", int'(xfer_cnt_a), 3);
`endif

        for (int i = 0; i < 10000; i++) begin
            @(posedge clk);
            #1 drive(($urandom_range(0, 3) != 0), 2'($urandom), DW'($urandom),
                     4'($urandom) | ((i % 64 < 8) ? 4'b0000 : 4'($urandom)));
        end

        @(posedge clk); #1 drive(1'b0, 2'd0, 4'h0, 4'b1111);
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("drained q[%0d]", k), q[k].size(), 0);
        end
        check("drained out_valid", int'(out_valid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/demux_1x4_stream.md
DEMUX_1X4_STREAM -- requirements
Module: demux_1x4_stream

Interface
REQ-001 Parameter DW, default 4, data width of input and each output channel.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  upstream word present on in_data/in_sel.
REQ-005 in_ready  output  1  block accepts the word this cycle.
REQ-006 in_data  input  DW  word to route.
REQ-007 in_sel  input  2  destination channel, 0..3.
REQ-008 out_valid  output  4  bit k: channel k holds a word.
REQ-009 out_ready  input  4  bit k: channel k consumer takes the word this cycle.
REQ-010 out_a, out_b, out_c, out_d  output  DW each  registered data of channels 0, 1, 2, 3.
REQ-011 xfer_cnt_a..xfer_cnt_d  output  8 each  per-channel accepted-word count (present only with DEMUX_CNT_EN).

Function
REQ-012 Each channel k SHALL own one holding register (data + valid bit), i.e. a one-entry buffer; channel states are EMPTY (out_valid[k]=0) and FULL (out_valid[k]=1).
REQ-013 Input handshake: transfer occurs when in_valid & in_ready at a rising edge.
REQ-014 in_ready SHALL be combinational: 1 when channel in_sel is EMPTY, or FULL with out_ready[in_sel]=1; independent of in_valid.
REQ-015 Output handshake on channel k: word leaves when out_valid[k] & out_ready[k] at a rising edge.
REQ-016 EMPTY->FULL: input transfer to k; register loads in_data; out_valid[k] rises next cycle (latency 1 cycle, in to out).
REQ-017 FULL->EMPTY: output handshake on k with no input transfer to k.
REQ-018 FULL->FULL with reload: output handshake on k and input transfer to k in the same cycle; register takes new in_data, out_valid[k] stays 1, no bubble.
REQ-019 FULL with out_ready[k]=0: out_a..d and out_valid[k] SHALL hold stable; channel k input stalls (in_ready=0 when in_sel=k).
REQ-020 Stall of one channel SHALL NOT block input traffic selecting another channel.
REQ-021 At most one channel loads per cycle; any number of channels may drain in the same cycle.
REQ-022 in_data/in_sel SHALL be ignored when in_valid=0; out_x data is don't-care when its valid is 0 but SHALL retain its last loaded value.
REQ-023 Words routed to the same channel SHALL emerge in input order; no word is duplicated or dropped.

Reset
REQ-024 rst_n=0 SHALL asynchronously clear out_valid to 4'b0000, out_a..out_d to 0 and all counters to 0, regardless of clock.
REQ-025 in_ready SHALL read 1 during reset (all channels EMPTY), but no transfer is recorded while rst_n=0.
REQ-026 Reset mid-operation discards all held words; first accepted word after release appears one cycle later per REQ-016.

Configuration
REQ-027 Macro DEMUX_CNT_EN: when defined, xfer_cnt_a..d ports exist; count k increments by 1 on each input transfer to channel k, wraps 255->0.
REQ-028 Without DEMUX_CNT_EN the counter ports and logic SHALL be absent; all other behaviour identical.

Verification
REQ-029 Reset release, in_valid=1, in_sel=2, in_data=4'hA, out_ready=0 -> next cycle out_valid=4'b0100, out_c=4'hA; following cycle in_ready=0 while in_sel=2.
REQ-030 Channel 1 FULL with 4'h3, out_ready[1]=1, in_sel=1 in_data=4'h7 in_valid=1 -> in_ready=1, next cycle out_b=4'h7, out_valid[1] stays 1.
REQ-031 Channel 0 FULL, out_ready=0; in_sel=3 in_data=4'h5 -> accepted, out_d=4'h5, out_a unchanged.
REQ-032 rst_n pulsed low mid-cycle with out_valid=4'b1111 -> out_valid=0 immediately, before next clk edge.
REQ-033 DEMUX_CNT_EN defined, 256 transfers to channel 0 -> xfer_cnt_a=0, others 0; 3 more -> xfer_cnt_a=3.
REQ-034 Random in_valid/in_sel/out_ready, 10000 cycles -> per-channel scoreboard: order preserved, no loss, no duplication.
